booth_pp_gen_pipe: RTL and testbench
====================================

Name: booth_pp_gen_pipe

Overview:
Parametrised, pipelined radix-4 Booth partial-product generator for the signed multipliers in the systolic PE array.
- Accepts signed operands a (multiplier) and b (multiplicand) of DATA_W bits.
- Produces NUM_PP = DATA_W/2 two's-complement partial products, registered behind a valid/ready handshake.
- Feeds the PE compressor tree; replaces the fixed 8-bit combinational generator and adds width scaling, pipelining and backpressure.

Parameters:
- DATA_W, 8, operand width in bits; must be even and >= 4.
- NUM_PP, DATA_W/2, number of partial products; derived, not overridable.
- PP_W, DATA_W+2, width of each partial product; two's complement, covers ±2·b.

Ports:
- clk  input  1  clock, all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept the operand pair this cycle.
- operand_a  input  DATA_W  signed multiplier, Booth-recoded.
- operand_b  input  DATA_W  signed multiplicand.
- out_valid  output  1  pp_o valid.
- out_ready  input  1  downstream accepts pp_o this cycle.
- pp_o  output  NUM_PP*PP_W  packed partial products; pp k occupies bits [k*PP_W +: PP_W], k=0 is LSB.
- pp_zero_o  output  NUM_PP  per-pp zero-digit flag; present only with BOOTH_ZERO_FLAG_EN.

Behaviour:
- Digit for k in 0..NUM_PP-1: d_k = -2·a[2k+1] + a[2k] + a[2k-1], with a[-1]=0. d_k ∈ {-2,-1,0,+1,+2}.
- pp_k = d_k·b, sign-extended to PP_W bits as an exact two's-complement value. No separate correction/sign bits.
- Σ pp_k·4^k = a·b, exactly, for all signed inputs, including a=b=-2^(DATA_W-1).
- Pipeline stages:
  - S1 registers operand_a, operand_b and the precomputed -b (DATA_W+1 bits) on an in_valid && in_ready transfer.
  - S2 registers the encoded partial products; S2 drives pp_o and out_valid.
- Latency: 2 cycles from input transfer to out_valid, with out_ready held high. Throughput: 1 result per cycle.
- Handshake (standard ready chain):
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready; combinational, no combinational in_valid→out_valid path.
- Transfer occurs when valid && ready at a stage. A stalled stage holds its data stable; out_valid never drops without an out_ready transfer.
- Simultaneous fill/drain: a full pipeline with out_ready=1 accepts a new input in the same cycle. No bubble is inserted.
- Capacity: at most 2 operand pairs in flight. With out_ready=0, in_ready falls once both stages are valid.
- Reset (async assert, sync-released by system):
  - s1_valid, s2_valid, out_valid = 0.
  - All data registers and pp_o = 0; pp_zero_o = 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards in-flight data without partial output.
- Data registers update only on transfer, which allows clock gating.

Optional Feature:
- Macro: BOOTH_ZERO_FLAG_EN.
- Defined:
  - pp_zero_o[k] = 1 when d_k = 0, registered alongside pp_o in S2 with the same timing and handshake.
  - Downstream uses it to skip compressor rows (sparsity gating).
  - pp_o is unchanged (all zeros for that slot).
- Undefined: pp_zero_o port and its flops are absent; all other behaviour is identical.

Decomposition:
- Shared package booth_pkg:
  - Digit enum booth_digit_t {BD_ZERO, BD_POS1, BD_POS2, BD_NEG1, BD_NEG2}.
  - Function booth_encode(3-bit slice) → booth_digit_t.
  - Localparam helpers for NUM_PP and PP_W.
- Sub-module booth_pp_slice: combinational, one 3-bit slice plus b and -b in, one PP_W product out (plus zero flag). Instantiated NUM_PP times via generate.
- Handshake and registers stay in the top module.

Test Plan:
- Encoding check, DATA_W=8: a=3, b=5, out_ready=1 → 2 cycles after transfer, pp0=10'h3FB (-5), pp1=10'h005, pp2=pp3=0. Zero flags (if enabled) = 4'b1100.
- Extreme operands, DATA_W=8: a=-128, b=-128 → pp3=10'h100 (+256), pp0..pp2=0. Σ pp_k·4^k = 16384.
- Backpressure: out_ready=0 while offering 3 back-to-back inputs → exactly 2 accepted, in_ready=0 on the third. Release out_ready → results emerge in order, none lost or duplicated, pp_o stable while stalled.
- Full throughput: 100 random pairs with out_ready=1 → one result per cycle after 2-cycle latency. Every result matches a·b when summed.
- Reset mid-operation: assert rst_n low with both stages valid → out_valid and pp_o go 0 immediately (asynchronously). After release, in_ready=1 and no stale result appears.
- DATA_W=16: a=16'hFFFF (-1), b=1234 → pp0=18'h3FB2E (-1234), pp1..pp7=0. Random 16-bit regression of 1000 pairs against the golden model.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth partial-product generator:
// digit encoding, the slice encoder and width helpers.
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_t;

  localparam int DEFAULT_DATA_W = 8;

  // Number of partial products produced for a given operand width.
  function automatic int num_pp(input int data_w);
    return data_w / 2;
  endfunction

  // Partial-product width: wide enough to hold +/-2*b exactly.
  function automatic int pp_w(input int data_w);
    return data_w + 2;
  endfunction

  // Map the overlapping triple {a[2k+1], a[2k], a[2k-1]} to its Booth digit.
  function automatic booth_digit_t booth_encode(input logic [2:0] slice);
    booth_digit_t digit;
    case (slice)
      3'b001, 3'b010: digit = BD_POS1;
      3'b011:         digit = BD_POS2;
      3'b100:         digit = BD_NEG2;
      3'b101, 3'b110: digit = BD_NEG1;
      default:        digit = BD_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_slice.sv
// One Booth row: encodes a 3-bit multiplier slice and selects
// 0, +b, +2b, -b or -2b as an exact PP_W-bit two's-complement value.
// -b arrives precomputed (DATA_W+1 bits) so -2^(DATA_W-1) negates cleanly.
module booth_pp_slice
  import booth_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int PP_W   = pp_w(DATA_W)
) (
  input  logic [2:0]        sel_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W:0]   nb_i,
  output logic [PP_W-1:0]   pp_o,
  output logic              zero_o
);

  booth_digit_t digit;

  // Digit decode and multiple selection with sign extension.
  always_comb begin
    digit  = booth_encode(sel_i);
    pp_o   = '0;
    zero_o = 1'b0;
    case (digit)
      BD_POS1: pp_o = {{2{b_i[DATA_W-1]}}, b_i};
      BD_POS2: pp_o = {b_i[DATA_W-1], b_i, 1'b0};
      BD_NEG1: pp_o = {nb_i[DATA_W], nb_i};
      BD_NEG2: pp_o = {nb_i, 1'b0};
      default: zero_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_pp_gen_pipe.sv
// Two-stage pipelined radix-4 Booth partial-product generator with a
// valid/ready chain. S1 holds the operands and -b, S2 holds the encoded
// partial products and drives the output.
// DATA_W must be even and >= 4.
// Optional: define BOOTH_ZERO_FLAG_EN to add the per-row zero-digit
// flags (pp_zero_o), registered alongside pp_o.
module booth_pp_gen_pipe
  import booth_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  localparam int NUM_PP = num_pp(DATA_W),
  localparam int PP_W   = pp_w(DATA_W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      operand_a,
  input  logic [DATA_W-1:0]      operand_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_PP*PP_W-1:0] pp_o
`ifdef BOOTH_ZERO_FLAG_EN
  ,
  output logic [NUM_PP-1:0]      pp_zero_o
`endif
);

  logic                   s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]      a_q, a_d;
  logic [DATA_W-1:0]      b_q, b_d;
  logic [DATA_W:0]        nb_q, nb_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [NUM_PP*PP_W-1:0] pp_q, pp_d;

  logic                   s1_ready, s2_ready;
  logic                   in_fire, s1_fire;
  logic [DATA_W:0]        a_ext;
  logic [NUM_PP*PP_W-1:0] pp_comb;
  logic [NUM_PP-1:0]      zero_comb;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid && s1_ready;
  assign s1_fire  = s1_valid_q && s2_ready;

  // a[-1] = 0 is the appended LSB.
  assign a_ext = {a_q, 1'b0};

  for (genvar k = 0; k < NUM_PP; k++) begin : g_slice
    booth_pp_slice #(.DATA_W(DATA_W)) u_slice (
      .sel_i  (a_ext[2*k+2:2*k]),
      .b_i    (b_q),
      .nb_i   (nb_q),
      .pp_o   (pp_comb[k*PP_W +: PP_W]),
      .zero_o (zero_comb[k])
    );
  end

  // S1 next state: load operands and -b only on an input transfer.
  always_comb begin
    s1_valid_d = in_fire || (s1_valid_q && !s2_ready);
    a_d        = a_q;
    b_d        = b_q;
    nb_d       = nb_q;
    if (in_fire) begin
      a_d  = operand_a;
      b_d  = operand_b;
      nb_d = {(DATA_W+1){1'b0}} - {operand_b[DATA_W-1], operand_b};
    end
  end

  // S1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      nb_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      nb_q       <= nb_d;
    end
  end

  // S2 next state: capture encoded rows when S1 hands over.
  always_comb begin
    s2_valid_d = s1_fire || (s2_valid_q && !out_ready);
    pp_d       = pp_q;
    if (s1_fire) begin
      pp_d = pp_comb;
    end
  end

  // S2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      pp_q       <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      pp_q       <= pp_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign pp_o      = pp_q;

`ifdef BOOTH_ZERO_FLAG_EN
  logic [NUM_PP-1:0] zero_q, zero_d;

  // Zero-digit flags follow the same S2 load enable as pp_o.
  always_comb begin
    zero_d = zero_q;
    if (s1_fire) begin
      zero_d = zero_comb;
    end
  end

  // Zero-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= '0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign pp_zero_o = zero_q;
`else
  logic unused_zero;
  assign unused_zero = &{1'b0, zero_comb};
`endif

endmodule

// File: tb/tb_booth_pp_gen_pipe.sv
// Scoreboard bench for booth_pp_gen_pipe: an 8-bit instance for encoding,
// backpressure, throughput and reset, and a 16-bit instance for the wide
// regression. Expected rows come from hand constants or an arithmetic
// digit model; every result is also summed and compared with a*b.
module tb_booth_pp_gen_pipe;

  typedef struct {
    logic [143:0] pp;
    logic [7:0]   z;
    longint       a;
    longint       b;
    int           cyc;
    bit           lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    op_a = '0;
  logic [7:0]    op_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [39:0]   pp_o;

  logic          in_valid16 = 1'b0;
  logic          in_ready16;
  logic [15:0]   op_a16 = '0;
  logic [15:0]   op_b16 = '0;
  logic          out_valid16;
  logic [143:0]  pp16;

`ifdef BOOTH_ZERO_FLAG_EN
  logic [3:0]    pp_zero_o;
  logic [7:0]    pp_zero16;
`endif

  int            checks = 0;
  int            errors = 0;
  int            cycn = 0;
  exp_t          q8[$];
  exp_t          q16[$];
  bit            prev_stall = 0;
  logic [39:0]   prev_pp = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cycn++;

  booth_pp_gen_pipe #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (op_a),
    .operand_b (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pp_o      (pp_o)
`ifdef BOOTH_ZERO_FLAG_EN
    ,
    .pp_zero_o (pp_zero_o)
`endif
  );

  booth_pp_gen_pipe #(.DATA_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .operand_a (op_a16),
    .operand_b (op_b16),
    .out_valid (out_valid16),
    .out_ready (1'b1),
    .pp_o      (pp16)
`ifdef BOOTH_ZERO_FLAG_EN
    ,
    .pp_zero_o (pp_zero16)
`endif
  );

  task automatic check(input string nm, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Digit from the defining formula d = -2*a[2k+1] + a[2k] + a[2k-1].
  function automatic longint digit_of(input longint a, input int k);
    longint am1, a0, a1;
    am1 = (k == 0) ? 0 : ((a >> (2*k-1)) & 1);
    a0  = (a >> (2*k)) & 1;
    a1  = (a >> (2*k+1)) & 1;
    return -2*a1 + a0 + am1;
  endfunction

  function automatic logic [143:0] model_pp(input longint a, input longint b, input int w);
    logic [143:0] v;
    logic [63:0]  pu;
    int           pw;
    v  = '0;
    pw = w + 2;
    for (int k = 0; k < w/2; k++) begin
      pu = digit_of(a, k) * b;
      for (int i = 0; i < pw; i++) v[k*pw+i] = pu[i];
    end
    return v;
  endfunction

  function automatic logic [7:0] model_z(input longint a, input int w);
    logic [7:0] z;
    z = '0;
    for (int k = 0; k < w/2; k++) z[k] = (digit_of(a, k) == 0);
    return z;
  endfunction

  function automatic longint pp_sum(input logic [143:0] v, input int w);
    longint s, x;
    int     pw;
    s  = 0;
    pw = w + 2;
    for (int k = 0; k < w/2; k++) begin
      x = 0;
      for (int i = 0; i < pw; i++) if (v[k*pw+i]) x = x | (longint'(1) << i);
      if (v[k*pw+pw-1]) x = x - (longint'(1) << pw);
      s = s + x * (longint'(1) << (2*k));
    end
    return s;
  endfunction

  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input logic [39:0] pp, input logic [3:0] z, input bit lat);
    exp_t e;
    int   n;
    bit   done;
    n = 0;
    done = 0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.pp  = {104'b0, pp};
        e.z   = {4'b0, z};
        e.a   = longint'($signed(a));
        e.b   = longint'($signed(b));
        e.cyc = cycn;
        e.lat = lat;
        q8.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (n > 200) begin
          check("send8_timeout", {143'b0, in_ready}, 144'd1);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send8_model(input logic [7:0] a, input logic [7:0] b, input bit lat);
    logic [143:0] v;
    logic [7:0]   z;
    v = model_pp(longint'($signed(a)), longint'($signed(b)), 8);
    z = model_z(longint'($signed(a)), 8);
    send8(a, b, v[39:0], z[3:0], lat);
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic [143:0] pp);
    exp_t e;
    int   n;
    bit   done;
    n = 0;
    done = 0;
    in_valid16 = 1'b1;
    op_a16 = a;
    op_b16 = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready16) begin
        e.pp  = pp;
        e.z   = model_z(longint'($signed(a)), 16);
        e.a   = longint'($signed(a));
        e.b   = longint'($signed(b));
        e.cyc = cycn;
        e.lat = 1;
        q16.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        n++;
        if (n > 200) begin
          check("send16_timeout", {143'b0, in_ready16}, 144'd1);
          done = 1;
        end
      end
    end
    in_valid16 = 1'b0;
  endtask

  // 8-bit monitor: stall stability, ordered pop-and-compare, sum and latency.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {143'b0, out_valid}, 144'd1);
        check("stall_pp", {104'b0, pp_o}, {104'b0, prev_pp});
      end
      if (out_valid && out_ready) begin
        if (q8.size() == 0) begin
          check("unexpected_out", {143'b0, out_valid}, 144'd0);
        end else begin
          e = q8.pop_front();
          check("pp8", {104'b0, pp_o}, e.pp);
          check("sum8", 144'(pp_sum({104'b0, pp_o}, 8)), 144'(e.a * e.b));
          if (e.lat) check("latency8", 144'(cycn - e.cyc), 144'd2);
`ifdef BOOTH_ZERO_FLAG_EN
          check("zero8", {140'b0, pp_zero_o}, {136'b0, e.z});
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_pp    = pp_o;
    end
  end

  // 16-bit monitor: always drained, so every valid cycle is a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid16) begin
      if (q16.size() == 0) begin
        check("unexpected_out16", {143'b0, out_valid16}, 144'd0);
      end else begin
        e = q16.pop_front();
        check("pp16", pp16, e.pp);
        check("sum16", 144'(pp_sum(pp16, 16)), 144'(e.a * e.b));
        check("latency16", 144'(cycn - e.cyc), 144'd2);
`ifdef BOOTH_ZERO_FLAG_EN
        check("zero16", {136'b0, pp_zero16}, {136'b0, e.z});
`endif
      end
    end
  end

  initial begin
    logic [7:0]   ra, rb;
    logic [15:0]  ra16, rb16;
    logic [143:0] v;
    int           n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {143'b0, out_valid}, 144'd0);
    check("rst_in_ready", {143'b0, in_ready}, 144'd1);
    check("rst_pp", {104'b0, pp_o}, 144'd0);
    check("rst_out_valid16", {143'b0, out_valid16}, 144'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Hand-computed encodings, pipeline draining freely.
    out_ready = 1'b1;
    send8(8'd3,    8'd5,    40'h00000017FB, 4'b1100, 1);
    send8(8'h80,   8'h80,   40'h4000000000, 4'b0111, 1);
    send8(8'hFF,   8'd7,    40'h00000003F9, 4'b1110, 1);
    send8(8'd2,    8'hFD,   40'h00000FF406, 4'b1100, 1);
    send8(8'd127,  8'd127,  40'h3F80000381, 4'b0110, 1);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two accepted, third refused until the output drains.
    out_ready = 1'b0;
    send8_model(8'd17,  8'hE3, 0);
    send8_model(8'h9C,  8'd45, 0);
    in_valid = 1'b1;
    op_a = 8'h55;
    op_b = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {143'b0, in_ready}, 144'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send8_model(8'h55, 8'hAA, 0);
    repeat (4) @(posedge clk);
    #1;

    // Back-to-back random traffic at full rate.
    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send8_model(ra, rb, 1);
    end
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages full and the output stalled.
    out_ready = 1'b0;
    send8_model(8'd99,  8'd77, 0);
    send8_model(8'hC1,  8'h3B, 0);
    check("pre_rst_valid", {143'b0, out_valid}, 144'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {143'b0, out_valid}, 144'd0);
    check("async_rst_pp", {104'b0, pp_o}, 144'd0);
    q8.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", {143'b0, in_ready}, 144'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", {143'b0, out_valid}, 144'd0);
    end
    @(posedge clk);
    #1;
    send8(8'd3, 8'd5, 40'h00000017FB, 4'b1100, 1);

    // 16-bit instance: hand vector then random regression.
    send16(16'hFFFF, 16'd1234, 144'h3FB2E);
    for (int i = 0; i < 1000; i++) begin
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      v = model_pp(longint'($signed(ra16)), longint'($signed(rb16)), 16);
      send16(ra16, rb16, v);
    end

    n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain8", 144'(q8.size()), 144'd0);
    check("drain16", 144'(q16.size()), 144'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
